// File: rtl/seg_display_scheduler_pkg.sv
// Shared definitions for the multiplexed 4-digit 7-segment display scheduler:
// display-source states, anode constants and the slot-to-anode table.
package seg_disp_pkg;

  localparam int NIBBLE_W = 4;
  localparam logic [3:0] AN_OFF = 4'b1111;

  typedef enum logic {
    SHOW_TIMER = 1'b0,
    SHOW_MSG   = 1'b1
  } disp_state_e;

  // Slot k drives anode bit k low; slot 0 is the rightmost digit.
  function automatic logic [3:0] slot_anode(input logic [1:0] slot);
    case (slot)
      2'd0:    return 4'b1110;
      2'd1:    return 4'b1101;
      2'd2:    return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

endpackage

// File: rtl/seg_display_scheduler_if.sv
// Display-source bus: timer and message inputs, message handshake, and the
// anode/digit outputs that feed the board and the external seg7 decoder.
interface seg_display_scheduler_if;
  logic [15:0] timer_bcd;
  logic [15:0] msg_bcd;
  logic        msg_req;
  logic        msg_ack;
  logic        msg_busy;
  logic        lz_blank;
  logic        blink_en;
  logic [3:0]  an;
  logic [3:0]  digit;

  modport master (
    output timer_bcd, msg_bcd, msg_req, lz_blank, blink_en,
    input  msg_ack, msg_busy, an, digit
  );

  modport slave (
    input  timer_bcd, msg_bcd, msg_req, lz_blank, blink_en,
    output msg_ack, msg_busy, an, digit
  );
endinterface

// File: rtl/seg_display_scheduler_prescaler.sv
// Free-running divider: tick is high for one cycle every DIV clocks.
module refresh_prescaler #(
  parameter int DIV = 50_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int DIV_C = (DIV < 1) ? 1 : DIV;
  localparam int CNT_W = (DIV_C > 1) ? $clog2(DIV_C) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV_C - 1);

  logic [CNT_W-1:0] count;

  assign tick = (count == LAST);

  // NOTE: state updates use <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n)     count <= '0;
    else if (tick)  count <= '0;
    else            count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/seg_display_scheduler.sv
// Scans the 4-digit display, arbitrates timer vs. held message, and applies
// leading-zero blanking and blink. Content changes only at frame boundaries.
module seg_display_scheduler
  import seg_disp_pkg::*;
#(
  parameter int REFRESH_DIV     = 50_000,
  parameter int MSG_HOLD_FRAMES = 1000,
  parameter int BLINK_FRAMES    = 125
) (
  input logic                    clk,
  input logic                    rst_n,
  seg_display_scheduler_if.slave bus
);

  localparam int HOLD_LOAD = (MSG_HOLD_FRAMES < 1) ? 1 : MSG_HOLD_FRAMES;
  localparam int HOLD_W    = $clog2(HOLD_LOAD + 1);
  localparam int BLINK_LEN = (BLINK_FRAMES < 1) ? 1 : BLINK_FRAMES;
  localparam int BLINK_W   = (BLINK_LEN > 1) ? $clog2(BLINK_LEN) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_LEN - 1);

  logic                slot_tick;
  logic                frame_tick;
  logic [1:0]          slot;

  disp_state_e         state, state_nxt;
  logic [HOLD_W-1:0]   hold, hold_nxt;
  logic [15:0]         msg_buf, msg_buf_nxt;
  logic                ack_nxt, ack_q;

  logic [15:0]         shadow;
  logic                shadow_timer;
  logic                blink_on;
  logic [BLINK_W-1:0]  blink_cnt;

  logic                lz_dark, blink_dark;
  logic [3:0]          an_nxt, digit_nxt;
  logic [3:0]          an_q, digit_q;

  refresh_prescaler #(.DIV(REFRESH_DIV)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (slot_tick)
  );

  assign frame_tick = slot_tick && (slot == 2'd3);

  always_ff @(posedge clk) begin
    if (!rst_n)          slot <= 2'd0;
    else if (slot_tick)  slot <= slot + 2'd1;
  end

  // A request always wins over hold expiry on the same cycle.
  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (no latch).
    state_nxt   = state;
    hold_nxt    = hold;
    msg_buf_nxt = msg_buf;
    ack_nxt     = 1'b0;
    if (bus.msg_req) begin
      state_nxt   = SHOW_MSG;
      hold_nxt    = HOLD_W'(HOLD_LOAD);
      msg_buf_nxt = bus.msg_bcd;
      ack_nxt     = 1'b1;
    end else if (state == SHOW_MSG && frame_tick) begin
      if (hold == HOLD_W'(1)) begin
        state_nxt = SHOW_TIMER;
        hold_nxt  = '0;
      end else begin
        hold_nxt  = hold - HOLD_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= SHOW_TIMER;
      hold    <= '0;
      msg_buf <= '0;
      ack_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      hold    <= hold_nxt;
      msg_buf <= msg_buf_nxt;
      ack_q   <= ack_nxt;
    end
  end

  // Shadow latches a whole frame's content so the scan never tears.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow       <= '0;
      shadow_timer <= 1'b1;
    end else if (frame_tick) begin
      shadow       <= (state == SHOW_MSG) ? msg_buf : bus.timer_bcd;
      shadow_timer <= (state == SHOW_TIMER);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blink_on  <= 1'b1;
      blink_cnt <= '0;
    end else if (frame_tick) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + BLINK_W'(1);
      end
    end
  end

  always_comb begin
    digit_nxt  = shadow[{slot, 2'b00} +: NIBBLE_W];
    lz_dark    = bus.lz_blank && shadow_timer &&
                 (((slot == 2'd3) && (shadow[15:12] == 4'h0)) ||
                  ((slot == 2'd2) && (shadow[15:8] == 8'h00)));
    blink_dark = bus.blink_en && !blink_on;
    an_nxt     = (lz_dark || blink_dark) ? AN_OFF : slot_anode(slot);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an_q    <= AN_OFF;
      digit_q <= 4'h0;
    end else begin
      an_q    <= an_nxt;
      digit_q <= digit_nxt;
    end
  end

  assign bus.an       = an_q;
  assign bus.digit    = digit_q;
  assign bus.msg_ack  = ack_q;
  assign bus.msg_busy = (state == SHOW_MSG);

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Self-checking bench for seg_display_scheduler: static display vectors, message
// and blink sequences, and randomized traffic against a frame-level model.
module tb_seg_display_scheduler;

  localparam int DIV   = 4;
  localparam int HOLD  = 3;
  localparam int BLINK = 2;
  localparam int FRAME = 4 * DIV;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg_display_scheduler_if bus();

  seg_display_scheduler #(
    .REFRESH_DIV     (DIV),
    .MSG_HOLD_FRAMES (HOLD),
    .BLINK_FRAMES    (BLINK)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: n counts clock edges since reset; slot, frame and blink
  // phase follow from n arithmetically. Message display is a frame countdown.
  int          n = 0;
  bit          mon_en = 1'b0;
  logic [15:0] m_shadow, m_buf;
  bit          m_from_timer, m_active;
  int          m_left;
  logic [3:0]  e_an, e_digit;
  logic        e_ack, e_busy;

  always @(posedge clk) begin
    int slot, frame;
    bit dark, ftick;
    if (!rst_n) begin
      n = 0; m_shadow = '0; m_buf = '0; m_from_timer = 1'b1;
      m_active = 1'b0; m_left = 0;
      e_an = 4'hF; e_digit = 4'h0; e_ack = 1'b0; e_busy = 1'b0;
      mon_en = 1'b1;
    end else if (mon_en) begin
      n++;
      slot  = ((n - 1) / DIV) % 4;
      frame = (n - 1) / FRAME;
      e_digit = m_shadow[slot*4 +: 4];
      dark = (bus.lz_blank && m_from_timer &&
              ((slot == 3 && m_shadow[15:12] == 4'h0) ||
               (slot == 2 && m_shadow[15:8] == 8'h00))) ||
             (bus.blink_en && ((frame / BLINK) % 2 == 1));
      e_an = dark ? 4'hF : ~(4'b0001 << slot);
      ftick = (n % FRAME == 0);
      if (ftick) begin
        m_shadow     = m_active ? m_buf : bus.timer_bcd;
        m_from_timer = !m_active;
      end
      if (bus.msg_req) begin
        m_buf = bus.msg_bcd; m_active = 1'b1; m_left = HOLD; e_ack = 1'b1;
      end else begin
        e_ack = 1'b0;
        if (m_active && ftick) begin
          m_left--;
          if (m_left == 0) m_active = 1'b0;
        end
      end
      e_busy = m_active;
    end
    #1;
    if (mon_en) begin
      check("mon_an",    bus.an,       e_an);
      check("mon_digit", bus.digit,    e_digit);
      check("mon_ack",   bus.msg_ack,  e_ack);
      check("mon_busy",  bus.msg_busy, e_busy);
    end
  end

  // Returns at the negedge right after a frame-boundary edge.
  task automatic wait_frame();
    int g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (n % FRAME != 0 && g < 100);
  endtask

  task automatic send_msg(input logic [15:0] v, output int r);
    bus.msg_bcd = v;
    bus.msg_req = 1'b1;
    @(negedge clk);
    bus.msg_req = 1'b0;
    r = n;
    check("ack_pulse", bus.msg_ack, 1);
    check("busy_set",  bus.msg_busy, 1);
    @(negedge clk);
    check("ack_single", bus.msg_ack, 0);
  endtask

  // Busy must drop right after the third frame edge following the request.
  task automatic wait_busy_drop(input int r);
    int target = FRAME * (r / FRAME + HOLD);
    int g = 0;
    while (bus.msg_busy === 1'b1 && g < 400) begin
      @(negedge clk);
      g++;
    end
    check("busy_drop_edge", n, target);
  endtask

  typedef struct {
    logic [15:0] timer;
    logic        lz;
    logic [15:0] an_exp;  // nibble k = anode pattern for slot k
  } vec_t;

  vec_t       vecs[7];
  logic [3:0] scan_tbl[4];

  initial begin
    int r, r2, cnt;
    bus.timer_bcd = '0; bus.msg_bcd = '0; bus.msg_req = 1'b0;
    bus.lz_blank = 1'b0; bus.blink_en = 1'b0;
    scan_tbl = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    vecs[0] = '{16'h0593, 1'b1, 16'hFBDE};
    vecs[1] = '{16'h0007, 1'b1, 16'hFFDE};
    vecs[2] = '{16'h0007, 1'b0, 16'h7BDE};
    vecs[3] = '{16'h1005, 1'b1, 16'h7BDE};
    vecs[4] = '{16'h0A0F, 1'b1, 16'hFBDE};
    vecs[5] = '{16'hFEDC, 1'b0, 16'h7BDE};
    vecs[6] = '{16'h0000, 1'b1, 16'hFFDE};

    // Reset values and anode scan order
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_an",    bus.an, 4'hF);
    check("rst_digit", bus.digit, 4'h0);
    check("rst_ack",   bus.msg_ack, 0);
    check("rst_busy",  bus.msg_busy, 0);
    bus.timer_bcd = 16'h1234;
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      check("scan_an", bus.an, scan_tbl[(i / DIV) % 4]);
      if (i == 15) check("pre_frame_digit", bus.digit, 4'h0);
      if (i == 16) check("first_frame_digit", bus.digit, 4'h4);
    end

    // Static display vectors
    foreach (vecs[v]) begin
      @(negedge clk);
      bus.timer_bcd = vecs[v].timer;
      bus.lz_blank  = vecs[v].lz;
      wait_frame();
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        check("vec_an",    bus.an,    vecs[v].an_exp[k*4 +: 4]);
        check("vec_digit", bus.digit, vecs[v].timer[k*4 +: 4]);
        repeat (DIV) @(negedge clk);
      end
    end

    // Message over a blanked timer: all four slots lit with message digits
    bus.timer_bcd = 16'h0007;
    bus.lz_blank  = 1'b1;
    send_msg(16'hABCD, r);
    wait_frame();
    repeat (3 * DIV + 1) @(negedge clk);
    check("msg_slot3_an",    bus.an, 4'b0111);
    check("msg_slot3_digit", bus.digit, 4'hA);
    wait_busy_drop(r);

    // Re-request during frame 2 of hold restarts the full hold
    send_msg(16'hABCD, r);
    while (n < FRAME * (r / FRAME + 1) + 6) @(negedge clk);
    send_msg(16'h1234, r2);
    wait_frame();
    @(negedge clk);
    check("rereq_an",    bus.an, 4'b1110);
    check("rereq_digit", bus.digit, 4'h4);
    wait_busy_drop(r2);

    // Request landing on the expiry edge keeps the message state
    send_msg(16'h5555, r);
    while (n < FRAME * (r / FRAME + HOLD) - 1) @(negedge clk);
    send_msg(16'h6666, r2);
    wait_busy_drop(r2);

    // Blink: exactly half of any 4-frame window is dark
    bus.lz_blank  = 1'b0;
    bus.timer_bcd = 16'h1234;
    bus.blink_en  = 1'b1;
    cnt = 0;
    for (int i = 0; i < 4 * FRAME; i++) begin
      @(negedge clk);
      if (bus.an === 4'hF) cnt++;
    end
    check("blink_dark_cycles", cnt, 2 * FRAME);
    bus.blink_en = 1'b0;
    cnt = 0;
    for (int i = 0; i < 4 * FRAME; i++) begin
      @(negedge clk);
      if (bus.an === 4'hF) cnt++;
    end
    check("noblink_dark_cycles", cnt, 0);

    // Reset mid-message discards it without an ack
    send_msg(16'h9999, r);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_an",    bus.an, 4'hF);
    check("midrst_digit", bus.digit, 4'h0);
    check("midrst_ack",   bus.msg_ack, 0);
    check("midrst_busy",  bus.msg_busy, 0);
    cnt = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      if (bus.msg_ack !== 1'b0 || bus.msg_busy !== 1'b0) cnt++;
    end
    check("midrst_quiet", cnt, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0)   bus.timer_bcd = 16'($urandom);
      if ($urandom_range(0, 63) == 0)  bus.lz_blank  = ~bus.lz_blank;
      if ($urandom_range(0, 127) == 0) bus.blink_en  = ~bus.blink_en;
      bus.msg_req = ($urandom_range(0, 39) == 0);
      if (bus.msg_req) bus.msg_bcd = 16'($urandom);
      rst_n = ($urandom_range(0, 1499) != 0);
    end
    @(negedge clk);
    bus.msg_req = 1'b0;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
